// File: rtl/mux8_sched_pkg.sv
// Shared constants, FSM state encoding and a one-hot helper for the mux8 round-robin scheduler.
package mux8_sched_pkg;

    localparam int N_SRC = 8;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] LAST_RST = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_SRC-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_sched_if.sv
// Request/grant/select/capture bundle between the requesters, the scheduler and the shared mux.
interface mux8_rr_sched_if;
    import mux8_sched_pkg::*;

    logic [N_SRC-1:0] req;
    logic             z_in;
    logic [SEL_W-1:0] sel;
    logic [N_SRC-1:0] gnt;
    logic             busy;
    logic             z_q;
    logic             z_vld;
    logic [SEL_W-1:0] z_src;

    modport master (
        output req, z_in,
        input  sel, gnt, busy, z_q, z_vld, z_src
    );

    modport slave (
        input  req, z_in,
        output sel, gnt, busy, z_q, z_vld, z_src
    );

endinterface

// File: rtl/Mux8_v.sv
// Combinational 8:1 single-bit multiplexer shared by the eight requesters.
module Mux8_v (
    input  logic [7:0] a,
    input  logic [2:0] sel,
    output logic       z
);

    assign z = a[sel];

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin finder: first set req bit searching last+1, last+2, ... (mod 8).
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_SRC-1:0] w_rot;
    logic [SEL_W-1:0] w_off;

    // w_rot[k] is the request at offset k+1 from last; offset 8 wraps back to last itself
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot
        assign w_rot[gi] = req[last + SEL_W'(gi + 1)];
    end

    always_comb begin
        w_off = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = SEL_W'(i);
        end
    end

    assign found = |w_rot;
    assign idx   = last + w_off + SEL_W'(1);

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin owner of the shared 8:1 mux: one-hot grant, mux select and tagged capture of z.
// Optional burst limiting is enabled with MUX8_SCHED_BURST_LIMIT_EN.
module mux8_rr_sched
    import mux8_sched_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux8_rr_sched_if.slave  bus
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST must be in 1..255");
    end

    state_t           r_state;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] r_sel;
    logic [N_SRC-1:0] r_gnt;
    logic             r_busy;
    logic             r_zq;
    logic             r_zvld;
    logic [SEL_W-1:0] r_zsrc;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic             w_drop;
    logic             w_rotate;
    logic             w_take;

    rr_pick8 u_pick (
        .req   (bus.req),
        .last  (r_last),
        .found (w_found),
        .idx   (w_idx)
    );

    // In BUSY r_last is always the current owner
    assign w_drop = (r_state == BUSY) && !bus.req[r_last];

`ifdef MUX8_SCHED_BURST_LIMIT_EN
    localparam int               CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_other;

    assign w_other  = w_found && (w_idx != r_last);
    assign w_rotate = (r_state == BUSY) && bus.req[r_last] && (r_cnt == CNT_LIM) && w_other;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            // at the limit with nobody waiting the owner simply starts a fresh burst
            r_cnt <= (r_cnt == CNT_LIM) ? '0 : r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_rotate = 1'b0;
`endif

    assign w_take = (w_found && ((r_state == IDLE) || w_drop)) || w_rotate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= LAST_RST;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_zq    <= 1'b0;
            r_zvld  <= 1'b0;
            r_zsrc  <= '0;
        end else begin
            r_zvld <= r_busy;
            if (r_busy) begin
                r_zq   <= bus.z_in;
                r_zsrc <= r_sel;
            end

            if (w_take) begin
                r_state <= BUSY;
                r_last  <= w_idx;
                r_sel   <= w_idx;
                r_gnt   <= onehot8(w_idx);
                r_busy  <= 1'b1;
            end else if (w_drop) begin
                r_state <= IDLE;
                r_gnt   <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign bus.sel   = r_sel;
    assign bus.gnt   = r_gnt;
    assign bus.busy  = r_busy;
    assign bus.z_q   = r_zq;
    assign bus.z_vld = r_zvld;
    assign bus.z_src = r_zsrc;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched with the shared Mux8_v; captured data checked through a scoreboard queue.
module tb_mux8_rr_sched;

    typedef struct packed {
        logic       z;
        logic [2:0] src;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] mux_a;
    int         checks;
    int         errors;
    exp_t       sb[$];

    mux8_rr_sched_if bus ();

    mux8_rr_sched #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    Mux8_v u_mux (
        .a   (mux_a),
        .sel (bus.sel),
        .z   (bus.z_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req_v, $time);
        end
    endtask

    // One clock edge; exp_owner < 0 means the scheduler must be idle after the edge.
    task automatic cyc(input int exp_owner);
        logic [7:0] eg;
        exp_t       e;
        @(posedge clk);
        #1;
        eg = (exp_owner < 0) ? 8'h00 : (8'h01 << exp_owner);
        chk("gnt", bus.gnt, eg);
        chk("busy", {7'b0, bus.busy}, {7'b0, (exp_owner >= 0)});
        if (exp_owner >= 0) begin
            chk("sel", {5'b0, bus.sel}, 8'(exp_owner));
            e.z   = mux_a[exp_owner];
            e.src = 3'(exp_owner);
            sb.push_back(e);
        end
    endtask

    // Monitor: every z_vld strobe must match the oldest expected capture
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.z_vld === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_zvld actual=1 required=0 at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("z_q", {7'b0, bus.z_q}, {7'b0, e.z});
                    chk("z_src", {5'b0, bus.z_src}, {5'b0, e.src});
                    $display("txn t=%0t z_src=%0d z_q=%0b", $time, bus.z_src, bus.z_q);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [7:0] RR_REQ [10] = '{8'hFF, 8'hFF, 8'hFE, 8'hFC, 8'hF8,
                                           8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h01};
    localparam int         RR_OWN [10] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0};
`ifdef MUX8_SCHED_BURST_LIMIT_EN
    localparam int         BU_OWN [11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`else
    localparam int         BU_OWN [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        mux_a   = 8'h0F;

        #7;
        chk("rst_gnt", bus.gnt, 8'h00);
        chk("rst_busy", {7'b0, bus.busy}, 8'h00);
        chk("rst_sel", {5'b0, bus.sel}, 8'h00);
        chk("rst_zq", {7'b0, bus.z_q}, 8'h00);
        chk("rst_zvld", {7'b0, bus.z_vld}, 8'h00);
        chk("rst_zsrc", {5'b0, bus.z_src}, 8'h00);
        #5;
        rst_n = 1'b1;
        cyc(-1);

        // First grant after reset goes to requester 0
        bus.req = 8'h01; cyc(0);
        bus.req = 8'h00; cyc(-1); cyc(-1);

        // Owner 2 hands over to waiting requester 5 on the same edge
        mux_a = 8'h20;
        bus.req = 8'h04; cyc(2); cyc(2);
        bus.req = 8'h24; cyc(2); cyc(2);
        bus.req = 8'h20; cyc(5); cyc(5);
        bus.req = 8'h00; cyc(-1);
        chk("sel_hold", {5'b0, bus.sel}, 8'd5);
        cyc(-1);

        // Index 7, non-owner drop, then full wrap with last=7
        mux_a = 8'h80;
        bus.req = 8'h80; cyc(7);
        bus.req = 8'h81; cyc(7);
        bus.req = 8'h80; cyc(7);
        bus.req = 8'h00; cyc(-1);
        bus.req = 8'h80; cyc(7);
        bus.req = 8'h00; cyc(-1); cyc(-1);

        // Full rotation with owners dropping in turn
        mux_a = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            bus.req = RR_REQ[k];
            cyc(RR_OWN[k]);
        end
        bus.req = 8'h00; cyc(-1); cyc(-1);

        // Asynchronous reset while requester 4 owns the mux
        mux_a = 8'h10;
        bus.req = 8'h10; cyc(4); cyc(4);
        chk("zvld_pre_rst", {7'b0, bus.z_vld}, 8'h01);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_gnt", bus.gnt, 8'h00);
        chk("arst_busy", {7'b0, bus.busy}, 8'h00);
        chk("arst_zvld", {7'b0, bus.z_vld}, 8'h00);
        chk("arst_sel", {5'b0, bus.sel}, 8'h00);
        @(posedge clk);
        #3;
        mux_a   = 8'h02;
        rst_n   = 1'b1;
        bus.req = 8'hFF; cyc(0);

        // Two persistent requesters: burst limit decides whether they alternate
        bus.req = 8'h03;
        for (int k = 0; k < 11; k++) begin
            cyc(BU_OWN[k]);
        end
        bus.req = 8'h00; cyc(-1);
        repeat (3) cyc(-1);

        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
